// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets
// (decoded from address[3:0]), the request FSM state encoding and the
// "no source" ID value.
package irq_pkg;

  localparam logic [3:0] PENDING_ADDR  = 4'h0;
  localparam logic [3:0] ENABLE_ADDR   = 4'h4;
  localparam logic [3:0] EDGE_SEL_ADDR = 4'h8;
  localparam logic [3:0] CLAIM_ADDR    = 4'hC;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_t;

  // Source i is reported as ID i+1, so 0 is free to mean "nothing".
  localparam int ID_NONE = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
//   vec : request vector, bit i is source i
//   id  : i+1 of the lowest set bit, 0 when vec is empty
module irq_prio_enc #(
  parameter int NUM_SOURCES = 8,
  parameter int ID_W        = 5
) (
  input  logic [NUM_SOURCES-1:0] vec,
  output logic [ID_W-1:0]        id
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller with claim/complete handshake.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   address          : byte address, only address[3:0] is decoded
//   wr_en, rd_en     : single-cycle access strobes
//   wr_data          : write data
//   rd_data          : combinational read data, 0 when rd_en is low
//   irq_src          : peripheral interrupt lines (same clock domain)
//   irq_out          : registered request to the CPU
//   irq_id           : registered ID of the current best candidate, 0 if none
// Registers: PENDING (W1C), ENABLE, EDGE_SEL (1 = rising edge), CLAIM
// (read = claim the presented ID, write = complete that ID).
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int ID_W        = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            address,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            wr_data,
  output logic [31:0]            rd_data,
  input  logic [NUM_SOURCES-1:0] irq_src,
  output logic                   irq_out,
  output logic [ID_W-1:0]        irq_id
);

  localparam int N = NUM_SOURCES;

  logic [N-1:0]    pending, enable, edge_sel, src_q;
  logic [N-1:0]    candidate, set_vec, clr_vec, claim_clr, pending_nxt;
  logic [ID_W-1:0] claimed_id, winner;
  irq_state_t      state, state_nxt;
  logic            claim_fire, complete;

  logic [3:0] reg_addr;
  logic       wr_pend, wr_enab, wr_edge, claim_rd, claim_wr;

  // Upper address bits and unused write data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{address[31:4], wr_data[31:N]};

  assign reg_addr = address[3:0];
  assign wr_pend  = wr_en && (reg_addr == PENDING_ADDR);
  assign wr_enab  = wr_en && (reg_addr == ENABLE_ADDR);
  assign wr_edge  = wr_en && (reg_addr == EDGE_SEL_ADDR);
  assign claim_rd = rd_en && (reg_addr == CLAIM_ADDR);
  assign claim_wr = wr_en && (reg_addr == CLAIM_ADDR);

  assign candidate = pending & enable;

  irq_prio_enc #(
    .NUM_SOURCES (N),
    .ID_W        (ID_W)
  ) u_prio_enc (
    .vec (candidate),
    .id  (winner)
  );

  // Edge sources fire on a 0->1 transition, level sources every cycle high.
  assign set_vec = (edge_sel & irq_src & ~src_q) | (~edge_sel & irq_src);

  // Claim retires the registered irq_id, not the live winner, so a source
  // arriving in the claim cycle can never be claimed unseen.
  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < N; i++) begin
      claim_clr[i] = claim_fire && (irq_id == ID_W'(i + 1));
    end
  end

  assign clr_vec     = (wr_pend ? wr_data[N-1:0] : '0) | claim_clr;
  // Set is OR-ed in last: a new event beats any same-cycle clear.
  assign pending_nxt = (pending & ~clr_vec) | set_vec;

  always_comb begin
    state_nxt  = state;
    claim_fire = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (candidate != '0) state_nxt = REQ;
      end
      REQ: begin
        if (candidate == '0) begin
          state_nxt = IDLE;
        end else if (claim_rd && (irq_id != ID_W'(ID_NONE))) begin
          claim_fire = 1'b1;
          state_nxt  = IN_SERVICE;
        end
      end
      IN_SERVICE: begin
        // Only the matching ID completes; ENABLE has no say here.
        if (claim_wr && (wr_data[ID_W-1:0] == claimed_id)) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= '0;
      pending    <= '0;
      enable     <= '0;
      edge_sel   <= '0;
      claimed_id <= '0;
      state      <= IDLE;
      irq_out    <= 1'b0;
      irq_id     <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= pending_nxt;
      if (wr_enab) enable   <= wr_data[N-1:0];
      if (wr_edge) edge_sel <= wr_data[N-1:0];
      if (claim_fire)    claimed_id <= irq_id;
      else if (complete) claimed_id <= '0;
      state   <= state_nxt;
      irq_out <= (state_nxt == REQ);
      irq_id  <= winner;
    end
  end

  // CLAIM only exposes an ID while a request is actually outstanding.
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (reg_addr)
        PENDING_ADDR:  rd_data[N-1:0] = pending;
        ENABLE_ADDR:   rd_data[N-1:0] = enable;
        EDGE_SEL_ADDR: rd_data[N-1:0] = edge_sel;
        CLAIM_ADDR:    if (state == REQ) rd_data[ID_W-1:0] = irq_id;
        default:       rd_data = '0;
      endcase
    end
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Memory-mapped interrupt controller that sits directly downstream of the timer and other peripherals. It consumes their interrupt lines and latches them into a pending register, masking each with an enable bit. It presents a single prioritised request to the CPU. A claim/complete handshake lets the CPU read the winning source ID and retire it, with one source in service at a time.

Parameters:
NUM_SOURCES, 8, number of interrupt inputs (1..31); source i has ID i+1, and ID 0 means none.
ID_W, 5, width of the source ID field; must satisfy 2^ID_W > NUM_SOURCES.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
address  input  32  byte address of register access.
wr_en  input  1  write strobe, single cycle.
rd_en  input  1  read strobe, single cycle.
wr_data  input  32  write data.
rd_data  output  32  read data, combinational from address/rd_en.
irq_src  input  NUM_SOURCES  interrupt lines from peripherals (timer interrupt on bit 0), same clock domain.
irq_out  output  1  registered interrupt request to CPU.
irq_id  output  ID_W  registered ID of the current highest-priority candidate, 0 if none.

Behaviour:
- Reset (async, rst=1): PENDING, ENABLE, EDGE_SEL, src_q, claimed_id = 0; state = IDLE; irq_out = 0; irq_id = 0.
- Register map (address[3:0]; other addresses: writes ignored, reads return 0):
  - 0x0 PENDING: read-only bits; write-1-to-clear.
  - 0x4 ENABLE: read/write.
  - 0x8 EDGE_SEL: read/write; 1 = rising-edge capture, 0 = level.
  - 0xC CLAIM: a read returns {0, irq_id}; a write is a completion.
  - Bits above NUM_SOURCES read 0 and ignore writes.
- rd_data = 0 when rd_en = 0. Never drives Z.
- Capture, per source each cycle:
  - src_q <= irq_src.
  - Edge mode sets pending on irq_src & ~src_q.
  - Level mode sets pending while irq_src = 1.
  - Set has priority over a same-cycle W1C clear or claim clear.
- Candidate: candidate = PENDING & ENABLE. The lowest index wins. irq_id <= winner ID, registered, so one cycle after the pending bit is visible.
- FSM states:
  - IDLE: irq_out = 0. Go to REQ when candidate != 0.
  - REQ: irq_out = 1.
    - Go back to IDLE if candidate becomes 0 (masked or cleared).
    - On a CLAIM read with irq_id != 0: clear PENDING[irq_id-1], claimed_id <= irq_id, go to IN_SERVICE.
    - A CLAIM read in REQ returns the registered irq_id.
  - IN_SERVICE: irq_out = 0 regardless of new pending bits; pending bits keep accumulating.
    - A CLAIM write with wr_data[ID_W-1:0] == claimed_id: claimed_id <= 0, go to IDLE.
    - A non-matching ID is ignored.
    - A CLAIM read in this state returns 0 and has no side effect.
- irq_out is registered from the next state, so it asserts 2 cycles after the irq_src edge: capture, then irq_id/state.
- A CLAIM read in IDLE returns 0 and has no side effect.
- A CLAIM read in the same cycle as a higher-priority source arriving: the claim uses the registered irq_id, never the newly arriving source.
- Level-mode source still high after claim: pending re-sets the next cycle and is re-requested only after completion.
- ENABLE cleared while IN_SERVICE: completion still accepted.

Decomposition:
- Package irq_pkg holds:
  - address constants PENDING_ADDR, ENABLE_ADDR, EDGE_SEL_ADDR, CLAIM_ADDR;
  - state enum irq_state_t {IDLE, REQ, IN_SERVICE};
  - ID_NONE = 0.
- Sub-module irq_prio_enc: parameterised combinational lowest-index-first encoder, NUM_SOURCES vector in, ID_W ID out (0 if empty).

Test Plan:
- Edge capture and claim:
  - Stimulus: ENABLE=0x01, EDGE_SEL=0x01, pulse irq_src[0] for 1 cycle.
  - Response: PENDING=0x01 next cycle; irq_out=1 and irq_id=1 one cycle later; CLAIM read returns 1; PENDING=0x00; irq_out=0.
  - Then CLAIM write 1 gives state IDLE.
- Priority:
  - Stimulus: ENABLE=0xFF, level mode, irq_src=0x0C held.
  - Response: claim returns 3; after completion, the next claim returns 3 again because the level is still high.
  - Then drop bit 2; the next claim returns 4.
- Masking:
  - Stimulus: edge-pulse source 5 with ENABLE=0x00.
  - Response: PENDING=0x20, irq_out stays 0; write ENABLE=0x20 and irq_out=1 within 2 cycles, irq_id=6.
- Completion mismatch:
  - Stimulus: claim ID 1, write CLAIM=2.
  - Response: still IN_SERVICE, irq_out=0; write CLAIM=1 returns to IDLE; a pending source 2 re-raises irq_out.
- W1C vs set race:
  - Stimulus: in the same cycle, write PENDING=0x01 and a rising edge on source 0.
  - Response: PENDING[0]=1.
- Async reset mid-service:
  - Stimulus: assert rst while IN_SERVICE with PENDING=0x0F.
  - Response: immediately all registers 0, irq_out=0, irq_id=0, state IDLE, before the next clk edge.
